// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the FIFO packet path: field widths, packet layout and
// drain FSM state encoding.
package fifo_pkt_pkg;

  localparam int unsigned SRC_W     = 8;
  localparam int unsigned DST_W     = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned PKT_BYTES = 6;
  localparam int unsigned PKT_W     = SRC_W + DST_W + DATA_W;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LAT_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  // src sits in the MSBs so the packet leaves most-significant byte first.
  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DST_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } pkt_t;

endpackage

// File: rtl/fifo_pkt_drain_ser.sv
// Byte serializer: loads one packet word and streams it out MSB byte first
// over valid/ready, holding byte/sop/eop stable while stalled.
module pkt_byte_ser
  import fifo_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              rstp,
  input  logic              load,
  input  pkt_t              word,
  output logic              valid,
  input  logic              ready,
  output logic [BYTE_W-1:0] data_byte,
  output logic              sop,
  output logic              eop
);

  logic [PKT_W-1:0] hold;
  logic [IDX_W-1:0] idx;
  logic             accept;

  assign accept    = valid && ready;
  assign data_byte = hold[PKT_W-1 -: BYTE_W];

  // The current byte always sits at the top of hold; shifting only on accept
  // keeps it stable across stalls.
  always_ff @(posedge clk) begin
    if (rstp) begin
      hold  <= '0;
      idx   <= '0;
      valid <= 1'b0;
      sop   <= 1'b0;
      eop   <= 1'b0;
    end else if (load) begin
      hold  <= word;
      idx   <= '0;
      valid <= 1'b1;
      sop   <= 1'b1;
      eop   <= 1'b0;
    end else if (accept) begin
      hold <= hold << BYTE_W;
      sop  <= 1'b0;
      if (idx == IDX_W'(PKT_BYTES - 1)) begin
        idx   <= '0;
        valid <= 1'b0;
        eop   <= 1'b0;
      end else begin
        idx <= idx + IDX_W'(1);
        eop <= (idx == IDX_W'(PKT_BYTES - 2));
      end
    end
  end

endmodule

// File: rtl/fifo_pkt_drain.sv
// Read-side engine for sync_fifo: pops one entry at a time, waits out the FIFO
// read latency, then hands the packet to the byte serializer.
module fifo_pkt_drain
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstp,
  input  logic              emptyp,
  output logic              readp,
  input  logic [SRC_W-1:0]  fifo_src,
  input  logic [DST_W-1:0]  fifo_dst,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             load;
  logic             last_accept;
  pkt_t             word;

  // FIFO outputs are only looked at in the single capture cycle.
  assign load        = (state == ST_WAIT) && (lat_cnt == '0);
  assign word        = '{src: fifo_src, dst: fifo_dst, data: fifo_data};
  assign last_accept = (state == ST_SEND) && tx_valid && tx_ready && tx_eop;

  always_ff @(posedge clk) begin
    if (rstp) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      readp     <= 1'b0;
      busy      <= 1'b0;
      pkt_count <= '0;
    end else begin
      readp <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!emptyp) begin
            state <= ST_POP;
            readp <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ST_POP: begin
          state   <= ST_WAIT;
          lat_cnt <= LAT_W'(RD_LAT - 1);
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state <= ST_SEND;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_SEND: begin
          if (last_accept) begin
            pkt_count <= pkt_count + CNT_W'(1);
            if (!emptyp) begin
              state <= ST_POP;
              readp <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  pkt_byte_ser u_ser (
    .clk       (clk),
    .rstp      (rstp),
    .load      (load),
    .word      (word),
    .valid     (tx_valid),
    .ready     (tx_ready),
    .data_byte (tx_byte),
    .sop       (tx_sop),
    .eop       (tx_eop)
  );

endmodule
